pam_rcv: RTL and testbench
==========================

Name: pam_rcv

Overview:
- Receive-side packet analyser; the counterpart of the packet generator.
- Sinks the 134-bit FAST packet stream returned from the FPGA OS, classifies each packet into one of four streams and counts packets and bits per stream.
- Computes one-way latency from the generator's TX timestamp against the LCM time base.
- Exposes all counters to the LCM; sits between the FPGA OS output port and the LCM register file.

Parameters:
- STREAM_NUM, 4, number of stream counters (stream ID is 2 bits).
- CNT_W, 64, width of every counter and timestamp.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- in_pam_data  in  134  FAST word: [133:132] 01 head, 11 middle, 10 tail; [131:128] invalid bytes (tail only); [127:0] data
- in_pam_data_wr  in  1  data word strobe
- in_pam_data_valid  in  1  packet good(1)/discard(0)
- in_pam_data_valid_wr  in  1  valid strobe, one per packet, at or after its tail
- out_pam_data_ready  out  1  sink ready
- pam_config_reset  in  1  clears all statistics (one-cycle pulse)
- rcv_enable  in  1  statistics accumulate only while high
- lcm2pam_time  in  64  global time base
- rcv_pkt_0_cnt .. rcv_pkt_3_cnt  out  64 each  good packets per stream
- rcv_bit_cnt  out  64  total good bits
- rcv_lat_min  out  64  minimum latency
- rcv_lat_max  out  64  maximum latency
- rcv_lat_sum  out  64  latency sum (mean is computed by software)
- rcv_err_cnt  out  64  framing/protocol errors

Behaviour:
- Reset (rst, or pam_config_reset):
  - All counters go to 0; rcv_lat_min goes to all-ones.
  - FSM returns to IDLE and the pending record is cleared.
  - out_pam_data_ready is 0 while rst is high and 1 otherwise; pam_config_reset does not drop ready.
- FSM, advancing only on in_pam_data_wr:
  - IDLE: a head word latches rx_time = lcm2pam_time and stream_id = data[89:88], then goes to META1. Any other word: err+1, stay in IDLE.
  - META1: latches tx_ts = data[63:0].
    - A middle word goes to BODY.
    - A tail word (packet of 2 words) completes the packet.
    - A head word: err+1, restart as a new head (META1).
  - BODY:
    - A middle word stays in BODY.
    - A tail word completes the packet and goes to IDLE.
    - A head word: err+1, drop the current packet, restart in META1.
- Byte count: bytes = words*16 − invalid; bits = bytes<<3. The word counter is 12 bits and saturates at 4095.
- Completion:
  - Writes the pending record {stream_id, bits, latency = rx_time − tx_ts (mod 2^64)} and sets pending=1.
  - If pending was already 1, the old record is overwritten and err+1.
- in_pam_data_valid_wr:
  - With pending=1 and valid=1 and rcv_enable=1, the update lands on the next cycle:
    - pkt_cnt[stream_id] += 1; bit_cnt += bits; lat_sum += latency
    - lat_min = min(lat_min, latency); lat_max = max(lat_max, latency)
  - pending clears.
  - valid=0 discards the record.
  - valid_wr with pending=0: err+1.
- Simultaneous completion and valid_wr in the same cycle: valid_wr consumes the newly completed record; there is no error.
- rcv_enable low: framing and errors are still tracked; statistics are frozen.
- Latency: an unsigned modular difference. A negative real difference appears as a huge value; no clamping.
- All counters wrap mod 2^64.
- Outputs are registered; statistic updates are visible 1 cycle after valid_wr.

Decomposition:
- Shared package (pgm/pam): FAST header codes (HEAD=2'b01, MID=2'b11, TAIL=2'b10), field offsets (stream ID [89:88], timestamp [63:0]), FSM state encoding.
- Sub-module pam_stat: owns the pending-record-to-counter update and the min/max/sum logic. The parser FSM stays in pam_rcv.

Test Plan:
- 4-word packet, stream 2, tail invalid=6, tx_ts=100, time at head=350, valid_wr valid=1 → rcv_pkt_2_cnt=1, rcv_bit_cnt=464, lat_min=lat_max=lat_sum=250.
- Two packets, latencies 40 then 10, then valid=0 on a third packet with latency 5 → min=10, max=40, sum=50, pkt count=2.
- Head, middle, head (no tail) → rcv_err_cnt=1; the second packet completes normally and is counted.
- Two completed packets before any valid_wr → err=1; only the second packet is counted when valid_wr arrives. An extra valid_wr afterwards → err=2.
- Tail in the same cycle as valid_wr with pending=0 → counted, err stays 0. pam_config_reset mid-packet → counters 0, lat_min all-ones, ready stays 1; the remainder words give err=1.
- tx_ts=0xFFFF_FFFF_FFFF_FFF0 with rx_time=0x10 → latency 0x20. rcv_enable=0 → no counter change.

Source files
------------

// File: rtl/pam_pkg.sv
// Shared definitions for the receive-side packet analyser: FAST header
// codes, field offsets, parser state encoding and the pending record type.
package pam_pkg;

  localparam int unsigned STREAM_NUM = 4;
  localparam int unsigned CNT_W      = 64;
  localparam int unsigned SID_W      = 2;
  localparam int unsigned WCNT_W     = 12;
  localparam int unsigned BYTE_W     = WCNT_W + 4;
  localparam int unsigned SID_LSB    = 88;
  localparam int unsigned TS_LSB     = 0;

  localparam logic [1:0] HDR_HEAD = 2'b01;
  localparam logic [1:0] HDR_MID  = 2'b11;
  localparam logic [1:0] HDR_TAIL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_META1 = 2'd1,
    ST_BODY  = 2'd2
  } state_t;

  typedef struct packed {
    logic [SID_W-1:0] sid;
    logic [CNT_W-1:0] bits;
    logic [CNT_W-1:0] lat;
  } rec_t;

  // bits = (words*16 - invalid) * 8
  function automatic logic [CNT_W-1:0] pkt_bits(input logic [WCNT_W-1:0] words,
                                                input logic [3:0] inv);
    logic [BYTE_W-1:0] bytes;
    bytes = {words, 4'b0000} - BYTE_W'(inv);
    return CNT_W'({bytes, 3'b000});
  endfunction

endpackage

// File: rtl/pam_stat.sv
// Statistics block: applies an accepted packet record to the per-stream
// packet counters, the bit counter and the latency min/max/sum.
// Ports: clk, clr (sync clear), upd (apply rec this cycle), rec (record),
//        pkt_cnt/bit_cnt/lat_min/lat_max/lat_sum (registered statistics).
module pam_stat
  import pam_pkg::*;
(
  input  logic                                clk,
  input  logic                                clr,
  input  logic                                upd,
  input  rec_t                                rec,
  output logic [STREAM_NUM-1:0][CNT_W-1:0]    pkt_cnt,
  output logic [CNT_W-1:0]                    bit_cnt,
  output logic [CNT_W-1:0]                    lat_min,
  output logic [CNT_W-1:0]                    lat_max,
  output logic [CNT_W-1:0]                    lat_sum
);

  // Counters wrap naturally; min starts at all-ones so the first sample wins.
  always_ff @(posedge clk) begin
    if (clr) begin
      pkt_cnt <= '0;
      bit_cnt <= '0;
      lat_min <= '1;
      lat_max <= '0;
      lat_sum <= '0;
    end else if (upd) begin
      pkt_cnt[rec.sid] <= pkt_cnt[rec.sid] + CNT_W'(1);
      bit_cnt          <= bit_cnt + rec.bits;
      lat_sum          <= lat_sum + rec.lat;
      if (rec.lat < lat_min) lat_min <= rec.lat;
      if (rec.lat > lat_max) lat_max <= rec.lat;
    end
  end

endmodule

// File: rtl/pam_rcv.sv
// Receive-side packet analyser. Parses the FAST word stream, builds a
// pending record per completed packet and commits it to the statistics on
// the packet's valid strobe.
// Ports: clk, rst (sync, active-high); in_pam_data/_wr (FAST words);
//        in_pam_data_valid/_valid_wr (per-packet verdict); out_pam_data_ready;
//        pam_config_reset (clear stats); rcv_enable (stats gate);
//        lcm2pam_time (time base); rcv_* (registered statistics).
module pam_rcv
  import pam_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [133:0] in_pam_data,
  input  logic         in_pam_data_wr,
  input  logic         in_pam_data_valid,
  input  logic         in_pam_data_valid_wr,
  output logic         out_pam_data_ready,
  input  logic         pam_config_reset,
  input  logic         rcv_enable,
  input  logic [63:0]  lcm2pam_time,
  output logic [63:0]  rcv_pkt_0_cnt,
  output logic [63:0]  rcv_pkt_1_cnt,
  output logic [63:0]  rcv_pkt_2_cnt,
  output logic [63:0]  rcv_pkt_3_cnt,
  output logic [63:0]  rcv_bit_cnt,
  output logic [63:0]  rcv_lat_min,
  output logic [63:0]  rcv_lat_max,
  output logic [63:0]  rcv_lat_sum,
  output logic [63:0]  rcv_err_cnt
);

  logic [1:0]   hdr;
  logic [3:0]   inv;
  logic [127:0] data;
  logic         clr;
  logic         unused_data;

  assign hdr  = in_pam_data[133:132];
  assign inv  = in_pam_data[131:128];
  assign data = in_pam_data[127:0];
  assign clr  = rst | pam_config_reset;
  assign unused_data = ^{data[127:SID_LSB+SID_W], data[SID_LSB-1:TS_LSB+CNT_W]};

  state_t             state, state_nxt;
  logic               start_c, ts_c, mid_c, done_c, ferr_c;
  logic [CNT_W-1:0]   rx_time, tx_ts, cur_ts;
  logic [SID_W-1:0]   sid;
  logic [WCNT_W-1:0]  wcnt, wcnt_inc;
  logic               pend;
  rec_t               pend_rec, new_rec, upd_rec;
  logic               upd_c, ow_err_c, orph_err_c;
  logic [STREAM_NUM-1:0][CNT_W-1:0] pkt_cnt;

  // Parser state register
  always_ff @(posedge clk) begin
    if (clr) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Parser next state and per-word actions
  always_comb begin
    state_nxt = state;
    start_c   = 1'b0;
    ts_c      = 1'b0;
    mid_c     = 1'b0;
    done_c    = 1'b0;
    ferr_c    = 1'b0;
    if (in_pam_data_wr) begin
      case (state)
        ST_IDLE: begin
          if (hdr == HDR_HEAD) begin
            start_c   = 1'b1;
            state_nxt = ST_META1;
          end else begin
            ferr_c = 1'b1;
          end
        end
        ST_META1, ST_BODY: begin
          case (hdr)
            HDR_HEAD: begin
              ferr_c    = 1'b1;
              start_c   = 1'b1;
              state_nxt = ST_META1;
            end
            HDR_MID: begin
              ts_c      = (state == ST_META1);
              mid_c     = 1'b1;
              state_nxt = ST_BODY;
            end
            HDR_TAIL: begin
              done_c    = 1'b1;
              state_nxt = ST_IDLE;
            end
            default: begin
              ferr_c    = 1'b1;
              state_nxt = ST_IDLE;
            end
          endcase
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // A tail straight after the head carries the timestamp in the same word
  assign cur_ts   = (state == ST_META1) ? data[TS_LSB +: CNT_W] : tx_ts;
  assign wcnt_inc = (wcnt == '1) ? wcnt : wcnt + WCNT_W'(1);

  assign new_rec.sid  = sid;
  assign new_rec.bits = pkt_bits(wcnt_inc, inv);
  assign new_rec.lat  = rx_time - cur_ts;

  // A strobe in the completion cycle takes the fresh record
  assign upd_rec    = done_c ? new_rec : pend_rec;
  assign upd_c      = in_pam_data_valid_wr & (done_c | pend) & in_pam_data_valid & rcv_enable;
  assign ow_err_c   = done_c & pend;
  assign orph_err_c = in_pam_data_valid_wr & ~pend & ~done_c;

  // Packet metadata capture
  always_ff @(posedge clk) begin
    if (clr) begin
      rx_time <= '0;
      tx_ts   <= '0;
      sid     <= '0;
      wcnt    <= '0;
    end else begin
      if (start_c) begin
        rx_time <= lcm2pam_time;
        sid     <= data[SID_LSB +: SID_W];
        wcnt    <= WCNT_W'(1);
      end else if (mid_c) begin
        wcnt    <= wcnt_inc;
      end
      if (ts_c) tx_ts <= data[TS_LSB +: CNT_W];
    end
  end

  // Pending record and error counter
  always_ff @(posedge clk) begin
    if (clr) begin
      pend        <= 1'b0;
      pend_rec    <= '0;
      rcv_err_cnt <= '0;
    end else begin
      if (in_pam_data_valid_wr) pend <= 1'b0;
      else if (done_c)          pend <= 1'b1;
      if (done_c) pend_rec <= new_rec;
      rcv_err_cnt <= rcv_err_cnt + CNT_W'(ferr_c) + CNT_W'(ow_err_c) + CNT_W'(orph_err_c);
    end
  end

  // Ready tracks the core reset only
  always_ff @(posedge clk) begin
    if (rst) out_pam_data_ready <= 1'b0;
    else     out_pam_data_ready <= 1'b1;
  end

  pam_stat u_stat (
    .clk     (clk),
    .clr     (clr),
    .upd     (upd_c),
    .rec     (upd_rec),
    .pkt_cnt (pkt_cnt),
    .bit_cnt (rcv_bit_cnt),
    .lat_min (rcv_lat_min),
    .lat_max (rcv_lat_max),
    .lat_sum (rcv_lat_sum)
  );

  assign rcv_pkt_0_cnt = pkt_cnt[0];
  assign rcv_pkt_1_cnt = pkt_cnt[1];
  assign rcv_pkt_2_cnt = pkt_cnt[2];
  assign rcv_pkt_3_cnt = pkt_cnt[3];

endmodule

// File: tb/tb_pam_rcv.sv
// Self-checking bench for pam_rcv: a vector table of packets with expected
// cumulative statistics, plus hand-written framing/timing corner sequences.
module tb_pam_rcv;

  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] M = 2'b11;
  localparam logic [1:0] T = 2'b10;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [133:0] in_pam_data = '0;
  logic         in_pam_data_wr = 1'b0;
  logic         in_pam_data_valid = 1'b0;
  logic         in_pam_data_valid_wr = 1'b0;
  logic         out_pam_data_ready;
  logic         pam_config_reset = 1'b0;
  logic         rcv_enable = 1'b1;
  logic [63:0]  lcm2pam_time = '0;
  logic [63:0]  rcv_pkt_0_cnt, rcv_pkt_1_cnt, rcv_pkt_2_cnt, rcv_pkt_3_cnt;
  logic [63:0]  rcv_bit_cnt, rcv_lat_min, rcv_lat_max, rcv_lat_sum, rcv_err_cnt;

  pam_rcv dut (
    .clk                  (clk),
    .rst                  (rst),
    .in_pam_data          (in_pam_data),
    .in_pam_data_wr       (in_pam_data_wr),
    .in_pam_data_valid    (in_pam_data_valid),
    .in_pam_data_valid_wr (in_pam_data_valid_wr),
    .out_pam_data_ready   (out_pam_data_ready),
    .pam_config_reset     (pam_config_reset),
    .rcv_enable           (rcv_enable),
    .lcm2pam_time         (lcm2pam_time),
    .rcv_pkt_0_cnt        (rcv_pkt_0_cnt),
    .rcv_pkt_1_cnt        (rcv_pkt_1_cnt),
    .rcv_pkt_2_cnt        (rcv_pkt_2_cnt),
    .rcv_pkt_3_cnt        (rcv_pkt_3_cnt),
    .rcv_bit_cnt          (rcv_bit_cnt),
    .rcv_lat_min          (rcv_lat_min),
    .rcv_lat_max          (rcv_lat_max),
    .rcv_lat_sum          (rcv_lat_sum),
    .rcv_err_cnt          (rcv_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] p0, p1, p2, p3;
    logic [63:0] bits, lmin, lmax, lsum, err;
  } snap_t;

  typedef struct {
    bit          clr;
    bit          en;
    int          nw;
    logic [1:0]  sid;
    logic [3:0]  inv;
    logic [63:0] tx;
    logic [63:0] rx;
    bit          v;
    snap_t       exp;
  } vec_t;

  snap_t sb_q[$];
  vec_t  vecs[8];
  int    checks = 0;
  int    errors = 0;

  function automatic snap_t mk(input logic [63:0] p0, p1, p2, p3, bits, lmin, lmax, lsum, err);
    snap_t s;
    s.p0 = p0; s.p1 = p1; s.p2 = p2; s.p3 = p3;
    s.bits = bits; s.lmin = lmin; s.lmax = lmax; s.lsum = lsum; s.err = err;
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic check_snap(input string tag);
    snap_t e;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard_empty got=0 want=1", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".pkt0"}, rcv_pkt_0_cnt, e.p0);
      chk({tag, ".pkt1"}, rcv_pkt_1_cnt, e.p1);
      chk({tag, ".pkt2"}, rcv_pkt_2_cnt, e.p2);
      chk({tag, ".pkt3"}, rcv_pkt_3_cnt, e.p3);
      chk({tag, ".bits"}, rcv_bit_cnt, e.bits);
      chk({tag, ".lmin"}, rcv_lat_min, e.lmin);
      chk({tag, ".lmax"}, rcv_lat_max, e.lmax);
      chk({tag, ".lsum"}, rcv_lat_sum, e.lsum);
      chk({tag, ".err"},  rcv_err_cnt, e.err);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic [1:0] hdr, input logic [3:0] inv, input logic [127:0] d,
                      input logic [63:0] t, input bit vw, input bit v);
    in_pam_data          = {hdr, inv, d};
    in_pam_data_wr       = 1'b1;
    lcm2pam_time         = t;
    in_pam_data_valid_wr = vw;
    in_pam_data_valid    = v;
    step();
    in_pam_data_wr       = 1'b0;
    in_pam_data_valid_wr = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Head carries sid and rx time; word 1 carries tx timestamp
  task automatic send_pkt(input int nw, input logic [1:0] sid, input logic [3:0] inv,
                          input logic [63:0] tx, input logic [63:0] rx, input bit tail_vw);
    logic [127:0] d;
    for (int i = 0; i < nw; i++) begin
      d = rnd128();
      if (i == 0) begin
        d[89:88] = sid;
        word(H, 4'd0, d, rx, 1'b0, 1'b0);
      end else begin
        if (i == 1) d[63:0] = tx;
        if (i == nw - 1) word(T, inv, d, {$urandom, $urandom}, tail_vw, 1'b1);
        else             word(M, 4'd0, d, {$urandom, $urandom}, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic vwr(input bit v);
    in_pam_data_valid_wr = 1'b1;
    in_pam_data_valid    = v;
    step();
    in_pam_data_valid_wr = 1'b0;
  endtask

  task automatic cfg_clr();
    pam_config_reset = 1'b1;
    step();
    pam_config_reset = 1'b0;
  endtask

  initial begin
    // Cumulative expectations; entries with clr start from a cleared block
    vecs[0] = '{clr:1, en:1, nw:4, sid:2, inv:6, tx:64'd100, rx:64'd350, v:1,
                exp:mk(0, 0, 1, 0, 464, 250, 250, 250, 0)};
    vecs[1] = '{clr:1, en:1, nw:2, sid:1, inv:0, tx:64'd1000, rx:64'd1040, v:1,
                exp:mk(0, 1, 0, 0, 256, 40, 40, 40, 0)};
    vecs[2] = '{clr:0, en:1, nw:3, sid:1, inv:15, tx:64'd2000, rx:64'd2010, v:1,
                exp:mk(0, 2, 0, 0, 520, 10, 40, 50, 0)};
    vecs[3] = '{clr:0, en:1, nw:5, sid:3, inv:0, tx:64'd3000, rx:64'd3005, v:0,
                exp:mk(0, 2, 0, 0, 520, 10, 40, 50, 0)};
    vecs[4] = '{clr:1, en:1, nw:2, sid:0, inv:0, tx:64'hFFFF_FFFF_FFFF_FFF0, rx:64'h10, v:1,
                exp:mk(1, 0, 0, 0, 256, 64'h20, 64'h20, 64'h20, 0)};
    vecs[5] = '{clr:0, en:0, nw:3, sid:3, inv:1, tx:64'd0, rx:64'd7, v:1,
                exp:mk(1, 0, 0, 0, 256, 64'h20, 64'h20, 64'h20, 0)};
    vecs[6] = '{clr:0, en:1, nw:2, sid:3, inv:8, tx:64'd500, rx:64'd400, v:1,
                exp:mk(1, 0, 0, 1, 448, 64'h20, 64'hFFFF_FFFF_FFFF_FF9C,
                       64'hFFFF_FFFF_FFFF_FFBC, 0)};
    vecs[7] = '{clr:1, en:1, nw:4100, sid:0, inv:0, tx:64'd77, rx:64'd77, v:1,
                exp:mk(1, 0, 0, 0, 524160, 0, 0, 0, 0)};

    // Reset state
    repeat (3) step();
    chk("ready_in_rst", 64'(out_pam_data_ready), 64'd0);
    sb_q.push_back(mk(0, 0, 0, 0, 0, ONES, 0, 0, 0));
    check_snap("reset");
    rst = 1'b0;
    step();
    step();
    chk("ready_after_rst", 64'(out_pam_data_ready), 64'd1);

    // Table-driven packets
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].clr) cfg_clr();
      rcv_enable = vecs[i].en;
      send_pkt(vecs[i].nw, vecs[i].sid, vecs[i].inv, vecs[i].tx, vecs[i].rx, 1'b0);
      vwr(vecs[i].v);
      sb_q.push_back(vecs[i].exp);
      check_snap($sformatf("vec%0d", i));
      rcv_enable = 1'b1;
    end

    // Head, middle, head: first packet dropped, second counted
    cfg_clr();
    word(H, 4'd0, rnd128(), 64'd5, 1'b0, 1'b0);
    word(M, 4'd0, rnd128(), 64'd6, 1'b0, 1'b0);
    send_pkt(3, 2'd1, 4'd0, 64'd50, 64'd60, 1'b0);
    vwr(1'b1);
    sb_q.push_back(mk(0, 1, 0, 0, 384, 10, 10, 10, 1));
    check_snap("restart");

    // Two completions before the strobe, then an orphan strobe
    cfg_clr();
    send_pkt(2, 2'd0, 4'd0, 64'd10, 64'd13, 1'b0);
    send_pkt(2, 2'd2, 4'd4, 64'd20, 64'd27, 1'b0);
    vwr(1'b1);
    sb_q.push_back(mk(0, 0, 1, 0, 224, 7, 7, 7, 1));
    check_snap("overwrite");
    vwr(1'b1);
    sb_q.push_back(mk(0, 0, 1, 0, 224, 7, 7, 7, 2));
    check_snap("orphan");

    // Tail and strobe in the same cycle
    cfg_clr();
    send_pkt(2, 2'd3, 4'd0, 64'd0, 64'd9, 1'b1);
    sb_q.push_back(mk(0, 0, 0, 1, 256, 9, 9, 9, 0));
    check_snap("tail_strobe");

    // Config reset mid-packet; the leftover tail is a framing error
    word(H, 4'd0, rnd128(), 64'd1, 1'b0, 1'b0);
    word(M, 4'd0, rnd128(), 64'd2, 1'b0, 1'b0);
    cfg_clr();
    chk("ready_cfg_clr", 64'(out_pam_data_ready), 64'd1);
    sb_q.push_back(mk(0, 0, 0, 0, 0, ONES, 0, 0, 0));
    check_snap("cfg_clr");
    word(T, 4'd0, rnd128(), 64'd3, 1'b0, 1'b0);
    sb_q.push_back(mk(0, 0, 0, 0, 0, ONES, 0, 0, 1));
    check_snap("leftover_tail");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
